// File: rtl/cnn_upsampling_nn_gen.sv
// Nearest-neighbour / zero-insert upsampler: buffers one channel-major frame,
// then streams it out scaled by SCALE in both dimensions over a valid/ready port.
module cnn_upsampling_nn_gen #(
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 64,
    parameter int CHANNEL_NUM  = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int SCALE        = 4,
    parameter int MODE         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  err_drop
);
    localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int FRAME_PIXELS = IMAGE_SIZE * CHANNEL_NUM;
    localparam int ADDR_WIDTH   = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int XW           = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int YW           = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW           = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int SW           = (SCALE > 1) ? $clog2(SCALE) : 1;

    typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
    logic [CW-1:0]           c_q, c_d;
    logic [YW-1:0]           r_q, r_d;
    logic [SW-1:0]           ry_q, ry_d;
    logic [XW-1:0]           x_q, x_d;
    logic [SW-1:0]           rx_q, rx_d;
    logic                    issued_all_q, issued_all_d;
    logic                    p1_valid_q, p1_valid_d;
    logic                    p1_zero_q, p1_zero_d;
    logic                    p1_last_q, p1_last_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    err_drop_q, err_drop_d;

    logic [DATA_WIDTH-1:0]   mem [FRAME_PIXELS];
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    wr_en, issue, out_adv, is_last;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr_q] <= pxl_in;
        if (issue) mem_rdata <= mem[rd_addr];
    end

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        row_base_d   = row_base_q;
        c_d          = c_q;
        r_d          = r_q;
        ry_d         = ry_q;
        x_d          = x_q;
        rx_d         = rx_q;
        issued_all_d = issued_all_q;
        p1_valid_d   = p1_valid_q;
        p1_zero_d    = p1_zero_q;
        p1_last_d    = p1_last_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        err_drop_d   = err_drop_q;

        in_ready   = (state_q == LOAD);
        wr_en      = in_ready && valid_in;
        out_adv    = !out_valid_q || out_ready;
        // Read stage may only advance when its result has somewhere to go.
        issue      = (state_q == EMIT) && !issued_all_q && (!p1_valid_q || out_adv);
        rd_addr    = row_base_q + ADDR_WIDTH'(x_q);
        is_last    = (c_q == CW'(CHANNEL_NUM - 1)) && (r_q == YW'(IMAGE_HEIGHT - 1)) &&
                     (ry_q == SW'(SCALE - 1)) && (x_q == XW'(IMAGE_WIDTH - 1)) &&
                     (rx_q == SW'(SCALE - 1));
        frame_done = out_valid_q && out_ready && out_last_q;

        if (valid_in && !in_ready) err_drop_d = 1'b1;

        if (wr_en) begin
            if (wr_addr_q == ADDR_WIDTH'(FRAME_PIXELS - 1)) begin
                wr_addr_d = '0;
                state_d   = EMIT;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        if (issue) begin
            issued_all_d = is_last;
            if (rx_q == SW'(SCALE - 1)) begin
                rx_d = '0;
                if (x_q == XW'(IMAGE_WIDTH - 1)) begin
                    x_d = '0;
                    if (ry_q == SW'(SCALE - 1)) begin
                        ry_d       = '0;
                        // Channel-major storage: the next row base is always +W.
                        row_base_d = row_base_q + ADDR_WIDTH'(IMAGE_WIDTH);
                        if (r_q == YW'(IMAGE_HEIGHT - 1)) begin
                            r_d = '0;
                            if (c_q == CW'(CHANNEL_NUM - 1)) begin
                                c_d        = '0;
                                row_base_d = '0;
                            end else begin
                                c_d = c_q + 1'b1;
                            end
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        ry_d = ry_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end else begin
                rx_d = rx_q + 1'b1;
            end
        end

        if (out_adv) begin
            out_valid_d = p1_valid_q;
            out_last_d  = p1_last_q;
            if (p1_valid_q) out_data_d = p1_zero_q ? '0 : mem_rdata;
        end

        if (issue) begin
            p1_valid_d = 1'b1;
            p1_zero_d  = (MODE != 0) && ((rx_q != '0) || (ry_q != '0));
            p1_last_d  = is_last;
        end else if (out_adv) begin
            p1_valid_d = 1'b0;
        end

        if (frame_done) begin
            state_d      = LOAD;
            issued_all_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            wr_addr_q    <= '0;
            row_base_q   <= '0;
            c_q          <= '0;
            r_q          <= '0;
            ry_q         <= '0;
            x_q          <= '0;
            rx_q         <= '0;
            issued_all_q <= 1'b0;
            p1_valid_q   <= 1'b0;
            p1_zero_q    <= 1'b0;
            p1_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            err_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            row_base_q   <= row_base_d;
            c_q          <= c_d;
            r_q          <= r_d;
            ry_q         <= ry_d;
            x_q          <= x_d;
            rx_q         <= rx_d;
            issued_all_q <= issued_all_d;
            p1_valid_q   <= p1_valid_d;
            p1_zero_q    <= p1_zero_d;
            p1_last_q    <= p1_last_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            err_drop_q   <= err_drop_d;
        end
    end

    assign pxl_out   = out_data_q;
    assign valid_out = out_valid_q;
    assign err_drop  = err_drop_q;

endmodule

// File: doc/cnn_upsampling_nn_gen.md
# cnn_upsampling_nn_gen

Parametrised nearest-neighbour upsampler for the DeepLabV3+ decoder path. It buffers one channel-major feature map of CHANNEL_NUM × IMAGE_HEIGHT × IMAGE_WIDTH pixels, then streams it out upscaled by an integer SCALE in both dimensions. It adds a zero-insert mode and a valid/ready output handshake with full backpressure. It replaces the fixed-factor, FIFO-aligned upsampler between the ASPP/concat stages and the following convolutions.

## Interface
- IMAGE_WIDTH, 64, input map width in pixels (≥1)
- IMAGE_HEIGHT, 64, input map height in pixels (≥1)
- CHANNEL_NUM, 7, channel count (≥1)
- DATA_WIDTH, 32, pixel width in bits
- SCALE, 4, integer upscale factor (1..8)
- MODE, 0, upscale mode: 0 = replicate (nearest), 1 = zero-insert (pixel at top-left of each SCALE×SCALE block, zeros elsewhere)
- Derived: IMAGE_SIZE = W·H; FRAME_PIXELS = IMAGE_SIZE·CHANNEL_NUM; ADDR_WIDTH = clog2(FRAME_PIXELS); counter widths are clog2 of each bound, minimum 1
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- valid_in  in  1  pxl_in qualifier
- pxl_in  in  DATA_WIDTH  input pixel, channel-major then row-major
- in_ready  out  1  block accepts input this cycle
- pxl_out  out  DATA_WIDTH  upscaled pixel
- valid_out  out  1  pxl_out qualifier
- out_ready  in  1  downstream accepts pxl_out
- frame_done  out  1  one-cycle pulse when the last output pixel of a frame is accepted
- err_drop  out  1  sticky; set when valid_in is high while in_ready is low

## Operation
- Storage: one FRAME_PIXELS × DATA_WIDTH memory with synchronous read. Write address increments on each accepted pixel.
- FSM states: LOAD, EMIT.
  - LOAD: in_ready = 1. Transition to EMIT on acceptance of pixel FRAME_PIXELS−1.
  - EMIT: in_ready = 0. Transition to LOAD in the cycle the last output is accepted; frame_done pulses in that same cycle.
- Output order, outermost to innermost: channel c, input row r, row repeat ry (0..SCALE−1), input column x, column repeat rx (0..SCALE−1).
- Each channel produces W·H·SCALE² outputs; each frame produces FRAME_PIXELS·SCALE².
- Read address = c·IMAGE_SIZE + r·W + x. Keep a row-base register updated incrementally (no multipliers in the datapath). Re-read the same input row for each ry.
- MODE 0: pxl_out = mem[addr].
- MODE 1: pxl_out = mem[addr] when rx = 0 and ry = 0, otherwise zero.
- SCALE = 1 degenerates to pass-through of the frame in stored order.
- Input while in_ready = 0 is discarded and sets err_drop. err_drop clears only on reset.
- Reset at any point:
  - state → LOAD, all counters → 0, partially loaded or emitted frame discarded.
  - Outputs after reset: pxl_out = 0, valid_out = 0, in_ready = 1, frame_done = 0, err_drop = 0.
  - Memory contents are not cleared.

## Timing
- Output is a registered valid/ready stage. When valid_out = 1 and out_ready = 0, pxl_out and valid_out hold unchanged.
- Never drop valid_out mid-frame except by reset. The internal read pipeline must stall with out_ready, using a skid or prefetch register as needed.
- First valid_out is asserted 2 cycles after the clock edge that accepts the last input pixel. With out_ready held high, it then sustains 1 output per cycle with no bubbles across column, row-repeat, row, or channel boundaries.
- LOAD is re-entered the cycle after frame_done. in_ready = 1 in that cycle, so back-to-back frames are allowed.
- Total frame latency with out_ready = 1: FRAME_PIXELS input cycles + 2 + FRAME_PIXELS·SCALE² output cycles.
- Counters saturate at nothing: each counter wraps to 0 at its bound and carries into the next level. All wraps coincide on the final output.

## Test plan
- W=2, H=2, C=1, SCALE=2, MODE=0; input 1,2,3,4; out_ready=1 → outputs 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4 on 16 consecutive cycles; first output 2 cycles after pixel 4; frame_done with the last output.
- Same configuration, MODE=1 → outputs 1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0.
- W=2, H=1, C=2, SCALE=3, MODE=0; input 5,6,7,8 → 5,5,5,6,6,6 repeated 3 times, then 7,7,7,8,8,8 repeated 3 times (36 outputs); no gap at the channel boundary.
- Backpressure: first case with out_ready toggling pseudo-randomly (seed-driven, ~50% duty) → identical output sequence; pxl_out stable for every cycle with valid_out=1 and out_ready=0.
- Overflow: drive valid_in=1 during EMIT with pxl_in=0xDEAD → output stream unchanged, err_drop=1 until reset.
- Reset mid-EMIT after 5 outputs → next cycle valid_out=0, in_ready=1; a new frame 9,10,11,12 yields 9,9,10,10,9,9,10,10,11,11,12,12,11,11,12,12.
